i3c_bus_frontend: RTL

Receive-side front end for the SCL/SDA pad inputs; it feeds the I3C controller core with clean line levels and bus events. It synchronises both lines to `clk_i`, removes spikes with a programmable glitch filter, and produces single-cycle edge strobes. It also detects START, repeated START and STOP, and tracks bus-busy and bus-idle state, so the core never samples raw pad levels.

---
 rtl/i3c_bus_frontend_pkg.sv | 23 ++
 rtl/i3c_bus_frontend_if.sv | 38 +++
 rtl/i3c_bus_frontend_line_filter.sv | 78 +++++++
 rtl/i3c_bus_frontend.sv | 112 +++++++++++
 4 files changed

// File: rtl/i3c_bus_frontend_pkg.sv
// Shared types and default widths for the I3C receive-side pad front end.
package i3c_phy_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int FILTER_W_DEFAULT    = 8;
  localparam int IDLE_W_DEFAULT      = 16;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } i3c_line_evt_t;

  typedef enum logic [0:0] {
    BUS_FREE = 1'b0,
    BUS_BUSY = 1'b1
  } i3c_bus_state_e;

  function automatic logic any_edge(input i3c_line_evt_t a, input i3c_line_evt_t b);
    return a.rise | a.fall | b.rise | b.fall;
  endfunction

endpackage

// File: rtl/i3c_bus_frontend_if.sv
// Pad inputs, filter/idle configuration and filtered bus events between the
// pad front end (slave) and the controller core or bench driving it (master).
interface i3c_bus_frontend_if
  import i3c_phy_pkg::*;
#(
  parameter int FilterW = FILTER_W_DEFAULT,
  parameter int IdleW   = IDLE_W_DEFAULT
);
  logic               scl_i;
  logic               sda_i;
  logic               filter_en_i;
  logic [FilterW-1:0] filter_cycles_i;
  logic [IdleW-1:0]   idle_cycles_i;
  logic               scl_o;
  logic               sda_o;
  logic               scl_rise_o;
  logic               scl_fall_o;
  logic               sda_rise_o;
  logic               sda_fall_o;
  logic               start_det_o;
  logic               rstart_det_o;
  logic               stop_det_o;
  logic               bus_busy_o;
  logic               bus_idle_o;

  modport master (
    output scl_i, sda_i, filter_en_i, filter_cycles_i, idle_cycles_i,
    input  scl_o, sda_o, scl_rise_o, scl_fall_o, sda_rise_o, sda_fall_o,
    input  start_det_o, rstart_det_o, stop_det_o, bus_busy_o, bus_idle_o
  );

  modport slave (
    input  scl_i, sda_i, filter_en_i, filter_cycles_i, idle_cycles_i,
    output scl_o, sda_o, scl_rise_o, scl_fall_o, sda_rise_o, sda_fall_o,
    output start_det_o, rstart_det_o, stop_det_o, bus_busy_o, bus_idle_o
  );

endinterface

// File: rtl/i3c_bus_frontend_line_filter.sv
// One bus line: synchroniser chain, spike filter and edge strobes derived from
// the filtered level. Everything resets to the pulled-up level.
module i3c_line_filter
  import i3c_phy_pkg::*;
#(
  parameter int SyncStages = SYNC_STAGES_DEFAULT,
  parameter int FilterW    = FILTER_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               line_i,
  input  logic               filter_en_i,
  input  logic [FilterW-1:0] filter_cycles_i,
  output i3c_line_evt_t      evt_o
);

  logic [SyncStages-1:0] sync_r;
  logic                  sync_s;
  logic                  filt_r;
  logic                  filt_q_r;
  logic                  filt_nxt_s;
  logic [FilterW-1:0]    cnt_r;
  logic [FilterW-1:0]    cnt_nxt_s;
  logic [FilterW-1:0]    len_s;
  logic [FilterW:0]      cnt_inc_s;

  // Synchroniser shift chain for the raw pad level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SyncStages-2:0], line_i};
    end
  end

  assign sync_s = sync_r[SyncStages-1];

  // Stability counter: the filtered level flips once the mismatch has lasted N cycles.
  always_comb begin
    len_s      = (filter_en_i && (filter_cycles_i != '0)) ? filter_cycles_i : FilterW'(1);
    cnt_inc_s  = {1'b0, cnt_r} + (FilterW + 1)'(1);
    filt_nxt_s = filt_r;
    cnt_nxt_s  = '0;
    if (sync_s != filt_r) begin
      if (cnt_inc_s >= {1'b0, len_s}) begin
        filt_nxt_s = ~filt_r;
        cnt_nxt_s  = '0;
      end else if (&cnt_r) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_inc_s[FilterW-1:0];
      end
    end else begin
      cnt_nxt_s = '0;
    end
  end

  // Filtered level, its one-cycle delayed copy and the stability counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_r   <= 1'b1;
      filt_q_r <= 1'b1;
      cnt_r    <= '0;
    end else begin
      filt_r   <= filt_nxt_s;
      filt_q_r <= filt_r;
      cnt_r    <= cnt_nxt_s;
    end
  end

  // Event bundle: strobes line up with the first cycle of the new level.
  always_comb begin
    evt_o.level = filt_r;
    evt_o.rise  = filt_r & ~filt_q_r;
    evt_o.fall  = ~filt_r & filt_q_r;
  end

endmodule

// File: rtl/i3c_bus_frontend.sv
// I3C receive front end: filtered SCL/SDA, START/Sr/STOP detection, bus-busy
// tracking and an idle timer that tells the core when the bus is free.
module i3c_bus_frontend
  import i3c_phy_pkg::*;
#(
  parameter int SyncStages = SYNC_STAGES_DEFAULT,
  parameter int FilterW    = FILTER_W_DEFAULT,
  parameter int IdleW      = IDLE_W_DEFAULT
) (
  input logic              clk_i,
  input logic              rst_i,
  i3c_bus_frontend_if.slave bus
);

  i3c_line_evt_t  scl_evt_s;
  i3c_line_evt_t  sda_evt_s;
  i3c_bus_state_e state_r;
  i3c_bus_state_e state_nxt_s;
  logic           scl_quiet_s;
  logic           start_s;
  logic           stop_s;
  logic           free_cond_s;
  logic           edge_s;
  logic [IdleW-1:0] idle_cnt_r;
  logic [IdleW-1:0] idle_cnt_nxt_s;

  i3c_line_filter #(.SyncStages(SyncStages), .FilterW(FilterW)) u_scl_filter (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .line_i          (bus.scl_i),
    .filter_en_i     (bus.filter_en_i),
    .filter_cycles_i (bus.filter_cycles_i),
    .evt_o           (scl_evt_s)
  );

  i3c_line_filter #(.SyncStages(SyncStages), .FilterW(FilterW)) u_sda_filter (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .line_i          (bus.sda_i),
    .filter_en_i     (bus.filter_en_i),
    .filter_cycles_i (bus.filter_cycles_i),
    .evt_o           (sda_evt_s)
  );

  // Bus conditions: SDA moves while SCL is steadily high; a concurrent SCL edge voids it.
  always_comb begin
    scl_quiet_s = ~(scl_evt_s.rise | scl_evt_s.fall);
    start_s     = sda_evt_s.fall & scl_evt_s.level & scl_quiet_s;
    stop_s      = sda_evt_s.rise & scl_evt_s.level & scl_quiet_s;
  end

  // Bus ownership state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= BUS_FREE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Busy from START until STOP; a repeated START keeps the bus busy.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BUS_FREE: begin
        if (start_s) state_nxt_s = BUS_BUSY;
        else         state_nxt_s = BUS_FREE;
      end
      BUS_BUSY: begin
        if (stop_s) state_nxt_s = BUS_FREE;
        else        state_nxt_s = BUS_BUSY;
      end
      default: state_nxt_s = BUS_FREE;
    endcase
  end

  // Idle timer counts consecutive quiet cycles with both lines high and no transaction.
  always_comb begin
    free_cond_s    = scl_evt_s.level & sda_evt_s.level & (state_r == BUS_FREE);
    edge_s         = any_edge(scl_evt_s, sda_evt_s);
    idle_cnt_nxt_s = idle_cnt_r;
    if (!free_cond_s || edge_s) begin
      idle_cnt_nxt_s = '0;
    end else if (&idle_cnt_r) begin
      idle_cnt_nxt_s = idle_cnt_r;
    end else begin
      idle_cnt_nxt_s = idle_cnt_r + IdleW'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_nxt_s;
    end
  end

  assign bus.scl_o        = scl_evt_s.level;
  assign bus.sda_o        = sda_evt_s.level;
  assign bus.scl_rise_o   = scl_evt_s.rise;
  assign bus.scl_fall_o   = scl_evt_s.fall;
  assign bus.sda_rise_o   = sda_evt_s.rise;
  assign bus.sda_fall_o   = sda_evt_s.fall;
  assign bus.start_det_o  = start_s;
  assign bus.rstart_det_o = start_s & (state_r == BUS_BUSY);
  assign bus.stop_det_o   = stop_s;
  assign bus.bus_busy_o   = (state_r == BUS_BUSY);
  assign bus.bus_idle_o   = free_cond_s & (idle_cnt_r >= bus.idle_cycles_i);

endmodule
